pfvf_rx_router: RTL

- FIM-side receive router for host-to-FPGA request packets.
- Decodes the PF number, VF number and VF-active flag carried on each packet's SOP beat.
- Steers the whole packet to one of 8 fixed function ports: the FIM-side counterpart of the host BFM's PF/VF addressing map.
- Packets addressed to an unmapped function are consumed, dropped and counted.

---
 rtl/pfvf_rx_router.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pfvf_rx_router.sv
// Receive router: decodes PF/VF/VF-active on each SOP beat and steers the packet
// to one of 8 function ports through a single-entry output register.
module pfvf_rx_router #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [2:0]        in_pf,
  input  logic [10:0]       in_vf,
  input  logic              in_vfa,
  input  logic [DATA_W-1:0] in_data,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  unmapped_cnt,
  output logic              unmapped_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_route;
  logic                r_obuf_valid;
  logic                r_obuf_sop;
  logic                r_obuf_eop;
  logic [DATA_W-1:0]   r_obuf_data;
  logic [2:0]          r_obuf_port;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pulse;

  logic                w_hit;
  logic [2:0]          w_dec_port;
  logic                w_space;
  logic                w_drain;
  logic                w_acc;
  logic                w_sop_acc;
  logic                w_load;
  logic [2:0]          w_load_port;
  logic                w_cnt_inc;

  // Function map: vfa=0 selects by PF alone, vfa=1 only PF0 with VF 0..2
  always_comb begin
    w_hit      = 1'b0;
    w_dec_port = 3'd0;
    if (!in_vfa) begin
      case (in_pf)
        3'd4: begin w_hit = 1'b1; w_dec_port = 3'd3; end
        3'd3: begin w_hit = 1'b1; w_dec_port = 3'd4; end
        3'd2: begin w_hit = 1'b1; w_dec_port = 3'd5; end
        3'd1: begin w_hit = 1'b1; w_dec_port = 3'd6; end
        3'd0: begin w_hit = 1'b1; w_dec_port = 3'd7; end
        default: ;
      endcase
    end else if (in_pf == 3'd0) begin
      case (in_vf)
        11'd2: begin w_hit = 1'b1; w_dec_port = 3'd0; end
        11'd1: begin w_hit = 1'b1; w_dec_port = 3'd1; end
        11'd0: begin w_hit = 1'b1; w_dec_port = 3'd2; end
        default: ;
      endcase
    end
  end

  assign w_drain = r_obuf_valid & out_ready[r_obuf_port];
  assign w_space = ~r_obuf_valid | out_ready[r_obuf_port];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_sop_acc && !in_eop) w_state_nxt = w_hit ? FWD : DROP;
      FWD:  if (w_acc && in_eop)      w_state_nxt = IDLE;
      DROP: if (w_acc && in_eop)      w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Non-SOP beats in IDLE are always discardable, so they never wait on the buffer
  always_comb begin
    in_ready    = 1'b0;
    w_load      = 1'b0;
    w_load_port = r_route;
    w_cnt_inc   = 1'b0;
    w_sop_acc   = 1'b0;
    case (r_state)
      IDLE:    in_ready = ~in_sop | w_space;
      FWD:     in_ready = w_space;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
    w_acc = in_valid & in_ready;
    case (r_state)
      IDLE: begin
        w_sop_acc = w_acc & in_sop;
        if (w_sop_acc) begin
          w_load      = w_hit;
          w_load_port = w_dec_port;
          w_cnt_inc   = ~w_hit;
        end
      end
      FWD:     w_load = w_acc;
      default: ;
    endcase
    out_valid = r_obuf_valid ? (8'b1 << r_obuf_port) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_obuf_valid <= 1'b0;
      r_obuf_sop   <= 1'b0;
      r_obuf_eop   <= 1'b0;
      r_obuf_port  <= '0;
      r_route      <= '0;
      r_cnt        <= '0;
      r_pulse      <= 1'b0;
    end else begin
      if (w_load) begin
        r_obuf_valid <= 1'b1;
        r_obuf_sop   <= in_sop & (r_state == IDLE);
        r_obuf_eop   <= in_eop;
        r_obuf_port  <= w_load_port;
      end else if (w_drain) begin
        r_obuf_valid <= 1'b0;
      end
      if (w_sop_acc) r_route <= w_dec_port;
      if (w_cnt_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      r_pulse <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) r_obuf_data <= in_data;
  end

  assign out_sop        = r_obuf_sop;
  assign out_eop        = r_obuf_eop;
  assign out_data       = r_obuf_data;
  assign unmapped_cnt   = r_cnt;
  assign unmapped_pulse = r_pulse;

endmodule
